// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and writeback
// all complete within one clk against a combinational ROM and data RAM.
module rv32i_single_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] read_data,
  output logic        mem_write,
  output logic [31:0] pc,
  output logic [31:0] alu_result,
  output logic [31:0] write_data
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  logic [31:0] r_pc;
  logic [31:0] r_rf [32];

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_u;
  logic [31:0] w_rs1_v;
  logic [31:0] w_rs2_v;

  assign w_op  = instr[6:0];
  assign w_f3  = instr[14:12];
  assign w_f7  = instr[31:25];
  assign w_rd  = instr[11:7];
  assign w_rs1 = instr[19:15];
  assign w_rs2 = instr[24:20];

  assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
  assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
  assign w_imm_u = {instr[31:12], 12'b0};

  assign w_rs1_v = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
  assign w_rs2_v = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];

  // Alternate funct7 (bit 30 set) is legal only for sub/sra/srai
  logic w_f7_zero;
  logic w_f7_alt;
  logic w_is_r;
  logic w_is_i;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_br;
  logic w_is_jal;
  logic w_is_jalr;
  logic w_is_lui;
  logic w_is_auipc;

  assign w_f7_zero = (w_f7 == 7'b0000000);
  assign w_f7_alt  = (w_f7 == 7'b0100000);

  assign w_is_r = (w_op == 7'b0110011) &&
                  (w_f7_zero || (w_f7_alt &&
                  (w_f3 == 3'b000 || w_f3 == 3'b101)));
  assign w_is_i = (w_op == 7'b0010011) &&
                  ((w_f3 == 3'b001) ? w_f7_zero :
                   (w_f3 == 3'b101) ? (w_f7_zero || w_f7_alt) :
                   1'b1);
  assign w_is_lw    = (w_op == 7'b0000011) && (w_f3 == 3'b010);
  assign w_is_sw    = (w_op == 7'b0100011) && (w_f3 == 3'b010);
  assign w_is_br    = (w_op == 7'b1100011);
  assign w_is_jal   = (w_op == 7'b1101111);
  assign w_is_jalr  = (w_op == 7'b1100111);
  assign w_is_lui   = (w_op == 7'b0110111);
  assign w_is_auipc = (w_op == 7'b0010111);

  alu_op_e     w_alu_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_alu;

  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_is_r || w_is_i) begin
      unique case (w_f3)
        3'b000: w_alu_op = (w_is_r && instr[30]) ? ALU_SUB : ALU_ADD;
        3'b001: w_alu_op = ALU_SLL;
        3'b010: w_alu_op = ALU_SLT;
        3'b011: w_alu_op = ALU_SLTU;
        3'b100: w_alu_op = ALU_XOR;
        3'b101: w_alu_op = instr[30] ? ALU_SRA : ALU_SRL;
        3'b110: w_alu_op = ALU_OR;
        3'b111: w_alu_op = ALU_AND;
        default: w_alu_op = ALU_ADD;
      endcase
    end
  end

  assign w_a = w_is_auipc ? r_pc : w_rs1_v;
  assign w_b = w_is_r     ? w_rs2_v :
               w_is_sw    ? w_imm_s :
               w_is_auipc ? w_imm_u : w_imm_i;

  always_comb begin
    w_alu = w_a + w_b;
    unique case (w_alu_op)
      ALU_ADD:  w_alu = w_a + w_b;
      ALU_SUB:  w_alu = w_a - w_b;
      ALU_SLL:  w_alu = w_a << w_b[4:0];
      ALU_SLT:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      ALU_SLTU: w_alu = {31'd0, w_a < w_b};
      ALU_XOR:  w_alu = w_a ^ w_b;
      ALU_SRL:  w_alu = w_a >> w_b[4:0];
      ALU_SRA:  w_alu = $signed(w_a) >>> w_b[4:0];
      ALU_OR:   w_alu = w_a | w_b;
      ALU_AND:  w_alu = w_a & w_b;
      default:  w_alu = w_a + w_b;
    endcase
  end

  logic w_eq;
  logic w_lt;
  logic w_ltu;
  logic w_taken;

  assign w_eq  = (w_rs1_v == w_rs2_v);
  assign w_lt  = ($signed(w_rs1_v) < $signed(w_rs2_v));
  assign w_ltu = (w_rs1_v < w_rs2_v);

  always_comb begin
    w_taken = 1'b0;
    if (w_is_br) begin
      unique case (w_f3)
        3'b000:  w_taken = w_eq;
        3'b001:  w_taken = !w_eq;
        3'b100:  w_taken = w_lt;
        3'b101:  w_taken = !w_lt;
        3'b110:  w_taken = w_ltu;
        3'b111:  w_taken = !w_ltu;
        default: w_taken = 1'b0;
      endcase
    end
  end

  logic [31:0] w_pc4;
  logic [31:0] w_tgt;
  logic [31:0] w_next_pc;
  logic [31:0] w_result;
  logic        w_reg_write;

  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_tgt = w_pc4;
    unique case (1'b1)
      w_is_jal:  w_tgt = r_pc + w_imm_j;
      w_is_jalr: w_tgt = w_alu & ~32'd1;
      w_taken:   w_tgt = r_pc + w_imm_b;
      default:   w_tgt = w_pc4;
    endcase
  end

  // Targets are never trapped; the low bits are simply dropped
  assign w_next_pc = {w_tgt[31:2], 2'b00};

  always_comb begin
    w_result = w_alu;
    unique case (1'b1)
      w_is_lw:                w_result = read_data;
      w_is_jal || w_is_jalr:  w_result = w_pc4;
      w_is_lui:               w_result = w_imm_u;
      default:                w_result = w_alu;
    endcase
  end

  assign w_reg_write = w_is_r | w_is_i | w_is_lw | w_is_jal |
                       w_is_jalr | w_is_lui | w_is_auipc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else begin
      r_pc <= w_next_pc;
      if (w_reg_write && (w_rd != 5'd0)) r_rf[w_rd] <= w_result;
    end
  end

  assign pc         = r_pc;
  assign alu_result = w_alu;
  assign write_data = w_rs2_v;
  assign mem_write  = w_is_sw & ~reset;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed bench for rv32i_single_cycle_core with a behavioural
// instruction ROM and data RAM; programs are hand-assembled.
module tb_rv32i_single_cycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr;
  logic [31:0] read_data;
  logic        mem_write;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic [31:0] write_data;

  logic [31:0] rom [256];
  logic [31:0] ram [256];
  int          n_st = 0;
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_d = 32'd0;

  int n_chk = 0;
  int n_fail = 0;

  localparam int OPI  = 32'h13;
  localparam int LD   = 32'h03;
  localparam int JALR = 32'h67;
  localparam int LUI  = 32'h37;
  localparam int AUI  = 32'h17;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  rv32i_single_cycle_core #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .read_data  (read_data),
    .mem_write  (mem_write),
    .pc         (pc),
    .alu_result (alu_result),
    .write_data (write_data)
  );

  always #5 clk = ~clk;

  assign instr     = rom[pc[9:2]];
  assign read_data = ram[alu_result[9:2]];

  always @(posedge clk) begin
    if (!reset && mem_write) begin
      ram[alu_result[9:2]] <= write_data;
      n_st   <= n_st + 1;
      last_a <= alu_result;
      last_d <= write_data;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_r(int f7, int f3, int rd,
                                      int rs1, int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] f_i(int op, int f3, int rd,
                                      int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] f_s(int rs2, int rs1, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'd2, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] f_b(int f3, int rs1, int rs2,
                                      int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] f_j(int rd, int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction

  function automatic logic [31:0] f_u(int op, int rd, int imm20);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction

  task automatic rom_clr();
    for (int i = 0; i < 256; i++) rom[i] = NOP;
  endtask

  task automatic rst_on();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) ram[i] = FILL;
    rom_clr();
  endtask

  task automatic rst_off();
    chk("rst_pc", pc, 32'h0);
    chk("rst_mw", {31'd0, mem_write}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  int exp_pc [12] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h18, 32'h14,
                      32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h30};
  int st0;

  initial begin
    // reset hold, store at pc 0 must stay masked
    #1;
    rst_on();
    rom[0] = f_s(0, 0, 0);
    rst_off();
    chk("t1_pc0", pc, 32'h0);
    step(1);
    chk("t1_pc4", pc, 32'h4);

    // addi/add/sw
    rst_on();
    rom[0] = f_i(OPI, 0, 2, 0, 5);
    rom[1] = f_i(OPI, 0, 3, 0, 12);
    rom[2] = f_r(0, 0, 4, 2, 3);
    rom[3] = f_s(4, 0, 32'h60);
    rom[4] = f_b(0, 0, 0, 0);
    rst_off();
    step(3);
    chk("t2_pc", pc, 32'hC);
    chk("t2_mw", {31'd0, mem_write}, 32'h1);
    chk("t2_wd", write_data, 32'h11);
    chk("t2_addr", alu_result, 32'h60);
    step(3);
    chk("t2_ram", ram[24], 32'h11);

    // branch/slt/lw/sw/jal program
    rst_on();
    rom[0]  = f_i(OPI, 0, 2, 0, 5);
    rom[1]  = f_i(OPI, 0, 3, 0, 12);
    rom[2]  = f_i(OPI, 0, 7, 3, -9);
    rom[3]  = f_r(0, 6, 4, 7, 2);
    rom[4]  = f_r(0, 7, 5, 3, 4);
    rom[5]  = f_r(0, 0, 5, 5, 4);
    rom[6]  = f_b(0, 5, 7, 48);
    rom[7]  = f_r(0, 2, 4, 3, 4);
    rom[8]  = f_b(0, 4, 0, 8);
    rom[9]  = f_i(OPI, 0, 5, 0, 0);
    rom[10] = f_r(0, 2, 4, 7, 2);
    rom[11] = f_r(0, 0, 7, 4, 5);
    rom[12] = f_r(32, 0, 7, 7, 2);
    rom[13] = f_s(7, 3, 84);
    rom[14] = f_i(LD, 2, 2, 0, 96);
    rom[15] = f_r(0, 0, 9, 2, 5);
    rom[16] = f_j(3, 8);
    rom[17] = f_i(OPI, 0, 2, 0, 1);
    rom[18] = f_r(0, 0, 2, 2, 9);
    rom[19] = f_s(2, 3, 32'h20);
    rom[20] = f_b(0, 2, 2, 0);
    st0 = n_st;
    rst_off();
    step(30);
    chk("t3_nst", n_st - st0, 32'd2);
    chk("t3_addr", last_a, 32'h64);
    chk("t3_data", last_d, 32'h19);
    chk("t3_ram60", ram[24], 32'h7);
    chk("t3_spin", pc, 32'h50);

    // sub/slt/sltu/shifts/immediates on -1 and 1
    rst_on();
    rom[0]  = f_i(OPI, 0, 5, 0, -1);
    rom[1]  = f_i(OPI, 0, 6, 0, 1);
    rom[2]  = f_i(OPI, 0, 11, 0, 4);
    rom[3]  = f_r(0, 2, 7, 5, 6);
    rom[4]  = f_r(0, 3, 8, 5, 6);
    rom[5]  = f_r(32, 5, 10, 5, 11);
    rom[6]  = f_r(32, 0, 12, 6, 5);
    rom[7]  = f_r(0, 5, 13, 5, 11);
    rom[8]  = f_r(0, 1, 14, 6, 11);
    rom[9]  = f_i(OPI, 4, 15, 6, -1);
    rom[10] = f_i(OPI, 3, 16, 6, -1);
    for (int k = 0; k < 8; k++) begin
      int rr [8] = '{7, 8, 10, 12, 13, 14, 15, 16};
      rom[11 + k] = f_s(rr[k], 0, 4 * k);
    end
    rom[19] = f_b(0, 0, 0, 0);
    rst_off();
    step(25);
    chk("t4_slt", ram[0], 32'h1);
    chk("t4_sltu", ram[1], 32'h0);
    chk("t4_sra", ram[2], 32'hFFFF_FFFF);
    chk("t4_sub", ram[3], 32'h2);
    chk("t4_srl", ram[4], 32'h0FFF_FFFF);
    chk("t4_sll", ram[5], 32'h10);
    chk("t4_xori", ram[6], 32'hFFFF_FFFE);
    chk("t4_sltiu", ram[7], 32'h1);

    // beq/bne/jal/jalr pc trace, x0 write discarded
    rst_on();
    rom[0]  = f_i(OPI, 0, 2, 0, 3);
    rom[1]  = f_b(0, 2, 0, 8);
    rom[2]  = f_b(1, 2, 0, 8);
    rom[3]  = f_i(OPI, 0, 3, 0, 99);
    rom[4]  = f_j(1, 8);
    rom[5]  = f_j(0, 12);
    rom[6]  = f_i(JALR, 0, 0, 1, 0);
    rom[8]  = f_i(OPI, 0, 0, 0, 7);
    rom[9]  = f_s(1, 0, 32'h40);
    rom[10] = f_s(0, 0, 32'h44);
    rom[11] = f_s(3, 0, 32'h48);
    rom[12] = f_b(0, 0, 0, 0);
    rst_off();
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t5_pc%0d", k), pc, exp_pc[k]);
      step(1);
    end
    chk("t5_x1", ram[16], 32'h14);
    chk("t5_x0", ram[17], 32'h0);
    chk("t5_skip", ram[18], 32'h0);

    // signed/unsigned branches and auipc
    rst_on();
    rom[0]  = f_i(OPI, 0, 5, 0, -1);
    rom[1]  = f_i(OPI, 0, 6, 0, 1);
    rom[2]  = f_b(4, 5, 6, 8);
    rom[3]  = f_i(OPI, 0, 20, 20, 1);
    rom[4]  = f_b(6, 5, 6, 8);
    rom[5]  = f_i(OPI, 0, 21, 0, 1);
    rom[6]  = f_b(5, 6, 5, 8);
    rom[7]  = f_i(OPI, 0, 20, 20, 1);
    rom[8]  = f_b(7, 6, 5, 8);
    rom[9]  = f_i(OPI, 0, 22, 0, 1);
    rom[10] = f_s(20, 0, 0);
    rom[11] = f_s(21, 0, 4);
    rom[12] = f_s(22, 0, 8);
    rom[13] = f_u(AUI, 23, 1);
    rom[14] = f_s(23, 0, 12);
    rom[15] = f_b(0, 0, 0, 0);
    rst_off();
    step(20);
    chk("t7_skip", ram[0], 32'h0);
    chk("t7_bltu", ram[1], 32'h1);
    chk("t7_bgeu", ram[2], 32'h1);
    chk("t7_auipc", ram[3], 32'h1034);

    // lui/addi/sw/lw round trip
    rst_on();
    rom[0] = f_u(LUI, 8, 32'h12345);
    rom[1] = f_i(OPI, 0, 8, 8, 32'h678);
    rom[2] = f_s(8, 0, 4);
    rom[3] = f_i(LD, 2, 9, 0, 4);
    rom[4] = f_s(9, 0, 8);
    rom[5] = f_b(0, 0, 0, 0);
    rst_off();
    step(2);
    chk("t6_mw", {31'd0, mem_write}, 32'h1);
    chk("t6_wd", write_data, 32'h1234_5678);
    chk("t6_addr", alu_result, 32'h4);
    step(5);
    chk("t6_lw", ram[2], 32'h1234_5678);

    // async reset mid-cycle clears pc and registers
    @(posedge clk);
    #2;
    rst_on();
    chk("t8_pc", pc, 32'h0);
    rom[0] = f_s(9, 0, 32'h10);
    rom[1] = f_s(8, 0, 32'h14);
    rom[2] = f_b(0, 0, 0, 0);
    rst_off();
    step(4);
    chk("t8_x9", ram[4], 32'h0);
    chk("t8_x8", ram[5], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
